// File: rtl/ti_share_codec_pkg.sv
// Shared types and constants for the 3-share threshold-implementation codec.
package ti_share_codec_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RND = 2'd1,
    HOLD     = 2'd2
  } mask_state_t;

endpackage

// File: rtl/ti_share_recombine.sv
// Unmask path: single-entry output register holding y1^y2^y3, 1-cycle latency.
// Accepts a new word whenever the slot is empty or draining this cycle.
module ti_share_recombine #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             u_in_valid,
  input  logic [WIDTH-1:0] u_in_y1,
  input  logic [WIDTH-1:0] u_in_y2,
  input  logic [WIDTH-1:0] u_in_y3,
  output logic             u_in_ready,
  output logic             u_out_valid,
  output logic [WIDTH-1:0] u_out_data,
  input  logic             u_out_ready
);

  assign u_in_ready = !u_out_valid || u_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_out_valid <= 1'b0;
      u_out_data  <= '0;
    end else if (u_in_valid && u_in_ready) begin
      u_out_valid <= 1'b1;
      u_out_data  <= u_in_y1 ^ u_in_y2 ^ u_in_y3;
    end else if (u_out_ready) begin
      u_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ti_share_codec.sv
// Masks a plain word into three shares (a1,a2,a4) using fresh randomness and
// recombines three S-box output shares; the two paths never stall each other.
module ti_share_codec
  import ti_share_codec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_in_valid,
  input  logic [WIDTH-1:0]   m_in_data,
  output logic               m_in_ready,
  input  logic               rnd_valid,
  input  logic [2*WIDTH-1:0] rnd_data,
  output logic               rnd_ready,
  output logic               m_out_valid,
  output logic [WIDTH-1:0]   m_out_a1,
  output logic [WIDTH-1:0]   m_out_a2,
  output logic [WIDTH-1:0]   m_out_a4,
  input  logic               m_out_ready,
  input  logic               u_in_valid,
  input  logic [WIDTH-1:0]   u_in_y1,
  input  logic [WIDTH-1:0]   u_in_y2,
  input  logic [WIDTH-1:0]   u_in_y3,
  output logic               u_in_ready,
  output logic               u_out_valid,
  output logic [WIDTH-1:0]   u_out_data,
  input  logic               u_out_ready
);

  mask_state_t      state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] share_src;

  assign r0 = rnd_data[WIDTH-1:0];
  assign r1 = rnd_data[2*WIDTH-1:WIDTH];

  // Randomness is only offered when a plain word is present or arriving, so
  // every accepted rnd word is bound to exactly one masking operation.
  assign m_in_ready = !rst && (state == IDLE);
  assign rnd_ready  = !rst && ((state == WAIT_RND) || ((state == IDLE) && m_in_valid));
  assign share_src  = (state == WAIT_RND) ? x_q : m_in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_q         <= '0;
      m_out_valid <= 1'b0;
      m_out_a1    <= '0;
      m_out_a2    <= '0;
      m_out_a4    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_in_valid) begin
            if (rnd_valid) begin
              m_out_a1    <= r0;
              m_out_a2    <= r1;
              m_out_a4    <= share_src ^ r0 ^ r1;
              m_out_valid <= 1'b1;
              x_q         <= '0;
              state       <= HOLD;
            end else begin
              x_q   <= m_in_data;
              state <= WAIT_RND;
            end
          end
        end
        WAIT_RND: begin
          if (rnd_valid) begin
            m_out_a1    <= r0;
            m_out_a2    <= r1;
            m_out_a4    <= share_src ^ r0 ^ r1;
            m_out_valid <= 1'b1;
            x_q         <= '0;  // plain word must not outlive the masking step
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (m_out_ready) begin
            m_out_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ti_share_recombine #(.WIDTH(WIDTH)) u_recombine (
    .clk        (clk),
    .rst        (rst),
    .u_in_valid (u_in_valid),
    .u_in_y1    (u_in_y1),
    .u_in_y2    (u_in_y2),
    .u_in_y3    (u_in_y3),
    .u_in_ready (u_in_ready),
    .u_out_valid(u_out_valid),
    .u_out_data (u_out_data),
    .u_out_ready(u_out_ready)
  );

endmodule

// File: tb/tb_ti_share_codec.sv
// Directed self-checking bench for ti_share_codec (mask, unmask, reset, round trip).
module tb_ti_share_codec;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_in_valid;
  logic [W-1:0] m_in_data;
  logic         m_in_ready;
  logic         rnd_valid;
  logic [2*W-1:0] rnd_data;
  logic         rnd_ready;
  logic         m_out_valid;
  logic [W-1:0] m_out_a1, m_out_a2, m_out_a4;
  logic         m_out_ready;
  logic         u_in_valid;
  logic [W-1:0] u_in_y1, u_in_y2, u_in_y3;
  logic         u_in_ready;
  logic         u_out_valid;
  logic [W-1:0] u_out_data;
  logic         u_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ti_share_codec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .m_in_valid(m_in_valid), .m_in_data(m_in_data), .m_in_ready(m_in_ready),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .m_out_valid(m_out_valid), .m_out_a1(m_out_a1), .m_out_a2(m_out_a2),
    .m_out_a4(m_out_a4), .m_out_ready(m_out_ready),
    .u_in_valid(u_in_valid), .u_in_y1(u_in_y1), .u_in_y2(u_in_y2),
    .u_in_y3(u_in_y3), .u_in_ready(u_in_ready),
    .u_out_valid(u_out_valid), .u_out_data(u_out_data), .u_out_ready(u_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2*W-1:0] r;
    logic [W-1:0]   s1, s2, s4;

    rst = 1'b1;
    m_in_valid = 0; m_in_data = '0; rnd_valid = 0; rnd_data = '0; m_out_ready = 0;
    u_in_valid = 0; u_in_y1 = '0; u_in_y2 = '0; u_in_y3 = '0; u_out_ready = 0;
    #1;
    chk("rst_m_in_ready", m_in_ready, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    step(); step();
    chk("rst_m_out_valid", m_out_valid, 0);
    chk("rst_u_out_valid", u_out_valid, 0);
    chk("rst_a4", m_out_a4, 0);
    rst = 1'b0;
    #1;
    chk("idle_m_in_ready", m_in_ready, 1);
    chk("idle_rnd_ready_no_word", rnd_ready, 0);

    // Word and randomness in the same cycle go straight to HOLD.
    m_in_valid = 1; m_in_data = 5'h13; rnd_valid = 1; rnd_data = 10'h2A5;
    #1;
    chk("direct_rnd_ready", rnd_ready, 1);
    step();
    m_in_valid = 0; rnd_valid = 1; rnd_data = 10'h3FF;
    chk("direct_valid", m_out_valid, 1);
    chk("direct_a1", m_out_a1, 5'h05);
    chk("direct_a2", m_out_a2, 5'h15);
    chk("direct_a4", m_out_a4, 5'h03);

    // Backpressure in HOLD: shares frozen, no readies, spare rnd ignored.
    for (int i = 0; i < 4; i++) begin
      chk("hold_m_in_ready", m_in_ready, 0);
      chk("hold_rnd_ready", rnd_ready, 0);
      chk("hold_valid", m_out_valid, 1);
      chk("hold_a1", m_out_a1, 5'h05);
      chk("hold_a4", m_out_a4, 5'h03);
      step();
    end
    rnd_valid = 0; m_out_ready = 1;
    step();
    chk("drain_valid", m_out_valid, 0);
    chk("drain_m_in_ready", m_in_ready, 1);
    m_out_ready = 0;

    // WAIT_RND for 3 cycles while the unmask path streams independently.
    m_in_valid = 1; m_in_data = 5'h1F;
    step();
    m_in_valid = 0; u_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      u_in_valid = 1; u_in_y1 = W'(i); u_in_y2 = 5'h10; u_in_y3 = 5'h00;
      chk("wait_rnd_ready", rnd_ready, 1);
      chk("wait_m_in_ready", m_in_ready, 0);
      chk("wait_no_out", m_out_valid, 0);
      chk("wait_u_in_ready", u_in_ready, 1);
      step();
      chk("indep_u_data", u_out_data, 5'h10 ^ i);
    end
    u_in_valid = 0;
    rnd_valid = 1; rnd_data = 10'h000;
    step();
    rnd_valid = 0;
    chk("wait_out_valid", m_out_valid, 1);
    chk("wait_a1", m_out_a1, 0);
    chk("wait_a2", m_out_a2, 0);
    chk("wait_a4", m_out_a4, 5'h1F);
    m_out_ready = 1;
    step();
    chk("wait_drained", m_out_valid, 0);

    // Back-to-back unmask, no bubbles.
    u_in_valid = 1; u_in_y1 = 5'h0A; u_in_y2 = 5'h11; u_in_y3 = 5'h04;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_u_in_ready", u_in_ready, 1);
      step();
      chk("b2b_u_valid", u_out_valid, 1);
      chk("b2b_u_data", u_out_data, 5'h1F);
    end
    u_in_valid = 0;
    step();
    chk("b2b_u_drained", u_out_valid, 0);

    // Unmask backpressure: slot full and output stalled blocks input.
    u_out_ready = 0; u_in_valid = 1; u_in_y1 = 5'h01; u_in_y2 = 5'h02; u_in_y3 = 5'h04;
    step();
    u_in_valid = 0;
    chk("bp_u_valid", u_out_valid, 1);
    chk("bp_u_data", u_out_data, 5'h07);
    chk("bp_u_in_ready", u_in_ready, 0);

    // Reset while in WAIT_RND discards everything.
    m_out_ready = 0; m_in_valid = 1; m_in_data = 5'h0C;
    step();
    m_in_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst_m_in_ready", m_in_ready, 0);
    chk("mid_rst_rnd_ready", rnd_ready, 0);
    chk("mid_rst_m_out_valid", m_out_valid, 0);
    chk("mid_rst_u_out_valid", u_out_valid, 0);
    chk("mid_rst_u_data", u_out_data, 0);
    chk("mid_rst_shares", {m_out_a1, m_out_a2, m_out_a4}, 0);
    step();
    rst = 0; rnd_valid = 1; rnd_data = 10'h155; m_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_rnd_ready", rnd_ready, 0);
      step();
      chk("post_rst_no_out", m_out_valid, 0);
    end
    rnd_valid = 0;

    // Round trip over all 32 words with random masks.
    u_out_ready = 1;
    for (int x = 0; x < 32; x++) begin
      r = 10'($urandom_range(0, 1023));
      m_in_valid = 1; m_in_data = W'(x); rnd_valid = 1; rnd_data = r;
      step();
      m_in_valid = 0; rnd_valid = 0;
      s1 = r[W-1:0];
      s2 = r[2*W-1:W];
      s4 = W'(x) ^ s1 ^ s2;
      chk("rt_m_valid", m_out_valid, 1);
      chk("rt_a1", m_out_a1, s1);
      chk("rt_a4", m_out_a4, s4);
      u_in_valid = 1; u_in_y1 = m_out_a1; u_in_y2 = m_out_a2; u_in_y3 = m_out_a4;
      step();
      u_in_valid = 0;
      chk("rt_u_valid", u_out_valid, 1);
      chk("rt_u_data", u_out_data, x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
